// File: rtl/mux_dff_pipe_pkg.sv
// Shared constants and helpers for the mux-into-register-pipeline block.
package mux_dff_pipe_pkg;

   // Width of the saturating accepted-beat counter.
   localparam int unsigned AcceptCntW = 16;

   // Select width: clog2 of the channel count, never narrower than one bit.
   function automatic int unsigned sel_width(input int unsigned channels);
      return (channels <= 2) ? 1 : $clog2(channels);
   endfunction

endpackage

// File: rtl/mux_dff_stage.sv
// One pipeline stage: data, channel tag and valid with hold-enable and flush.
module mux_dff_stage #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SEL_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_data,
   input  logic [SEL_W-1:0] i_sel,
   input  logic             i_valid,
   output logic [WIDTH-1:0] o_data,
   output logic [SEL_W-1:0] o_sel,
   output logic             o_valid
);

   logic [WIDTH-1:0] r_data;
   logic [SEL_W-1:0] r_sel;
   logic             r_valid;

   // Flush only kills the valid bit; payload registers keep their last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_sel   <= '0;
         r_valid <= 1'b0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_en) begin
         r_data  <= i_data;
         r_sel   <= i_sel;
         r_valid <= i_valid;
      end
   end

   assign o_data  = r_data;
   assign o_sel   = r_sel;
   assign o_valid = r_valid;

endmodule

// File: rtl/mux_dff_pipe.sv
// Channel mux feeding a DEPTH-stage register pipeline, with select-error
// flag and saturating count of accepted beats.
module mux_dff_pipe
   import mux_dff_pipe_pkg::*;
#(
   parameter  int unsigned WIDTH    = 8,
   parameter  int unsigned CHANNELS = 4,
   parameter  int unsigned DEPTH    = 2,
   localparam int unsigned SEL_W    = sel_width(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      flush,
   input  logic                      in_valid,
   input  logic [SEL_W-1:0]          sel,
   input  logic [CHANNELS*WIDTH-1:0] data,
   output logic [WIDTH-1:0]          Q,
   output logic                      q_valid,
   output logic [SEL_W-1:0]          q_sel,
   output logic                      sel_err,
   output logic [AcceptCntW-1:0]     accept_cnt
);

   logic [WIDTH-1:0]            w_mux_data;
   logic                        w_sel_ok;
   logic                        w_accept;
   logic [DEPTH:0][WIDTH-1:0]   w_chain_data;
   logic [DEPTH:0][SEL_W-1:0]   w_chain_sel;
   logic [DEPTH:0]              w_chain_valid;
   logic                        r_sel_err;
   logic [AcceptCntW-1:0]       r_accept_cnt;

   // Combinational channel select; an out-of-range select yields zero data.
   always_comb begin
      w_mux_data = '0;
      w_sel_ok   = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (sel == SEL_W'(k)) begin
            w_mux_data = data[k*WIDTH +: WIDTH];
            w_sel_ok   = 1'b1;
         end
      end
   end

   assign w_chain_data[0]  = w_mux_data;
   assign w_chain_sel[0]   = sel;
   assign w_chain_valid[0] = in_valid & w_sel_ok;

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      mux_dff_stage #(
         .WIDTH (WIDTH),
         .SEL_W (SEL_W)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_en    (en),
         .i_flush (flush),
         .i_data  (w_chain_data[g]),
         .i_sel   (w_chain_sel[g]),
         .i_valid (w_chain_valid[g]),
         .o_data  (w_chain_data[g+1]),
         .o_sel   (w_chain_sel[g+1]),
         .o_valid (w_chain_valid[g+1])
      );
   end

   // A beat counts only if it actually enters the pipe as valid.
   assign w_accept = en & in_valid & ~flush & w_sel_ok;

   // Sticky select error and saturating accept counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel_err    <= 1'b0;
         r_accept_cnt <= '0;
      end else begin
         if (en && in_valid && !w_sel_ok) begin
            r_sel_err <= 1'b1;
         end
         if (w_accept && (r_accept_cnt != '1)) begin
            r_accept_cnt <= r_accept_cnt + AcceptCntW'(1);
         end
      end
   end

   assign Q          = w_chain_data[DEPTH];
   assign q_sel      = w_chain_sel[DEPTH];
   assign q_valid    = w_chain_valid[DEPTH];
   assign sel_err    = r_sel_err;
   assign accept_cnt = r_accept_cnt;

endmodule

// File: tb/tb_mux_dff_pipe.sv
// Directed bench with a scoreboard of expected output beats for mux_dff_pipe.
module tb_mux_dff_pipe;

   localparam int unsigned DEPTH = 2;

   logic        clk;
   logic        rst_n;
   logic        en, flush, in_valid;
   logic [1:0]  sel;
   logic [31:0] data;
   logic [7:0]  Q;
   logic        q_valid;
   logic [1:0]  q_sel;
   logic        sel_err;
   logic [15:0] accept_cnt;

   logic        en3, in_valid3;
   logic [1:0]  sel3;
   logic [23:0] data3;
   logic [7:0]  Q3;
   logic        q_valid3;
   logic [1:0]  q_sel3;
   logic        sel_err3;
   logic [15:0] accept_cnt3;
   logic        flush3;

   int n_checks;
   int n_errors;

   typedef struct {
      logic [7:0] d;
      logic [1:0] s;
      int         age;
   } sb_t;

   sb_t         sb[$];
   logic        exp_qv;
   logic [7:0]  exp_q;
   logic [1:0]  exp_qs;
   logic [15:0] exp_cnt;

   mux_dff_pipe #(
      .WIDTH    (8),
      .CHANNELS (4),
      .DEPTH    (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .flush      (flush),
      .in_valid   (in_valid),
      .sel        (sel),
      .data       (data),
      .Q          (Q),
      .q_valid    (q_valid),
      .q_sel      (q_sel),
      .sel_err    (sel_err),
      .accept_cnt (accept_cnt)
   );

   mux_dff_pipe #(
      .WIDTH    (8),
      .CHANNELS (3),
      .DEPTH    (2)
   ) dut3 (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en3),
      .flush      (flush3),
      .in_valid   (in_valid3),
      .sel        (sel3),
      .data       (data3),
      .Q          (Q3),
      .q_valid    (q_valid3),
      .q_sel      (q_sel3),
      .sel_err    (sel_err3),
      .accept_cnt (accept_cnt3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Update the scoreboard for the coming edge, clock it, then compare.
   task automatic step();
      logic acc;
      acc = en && in_valid && !flush;
      if (flush) begin
         sb.delete();
         exp_qv = 1'b0;
      end else if (en) begin
         foreach (sb[i]) sb[i].age++;
         if (acc) sb.push_back('{d: data[int'(sel)*8 +: 8], s: sel, age: 0});
         if (sb.size() > 0 && sb[0].age == int'(DEPTH) - 1) begin
            exp_qv = 1'b1;
            exp_q  = sb[0].d;
            exp_qs = sb[0].s;
            void'(sb.pop_front());
         end else begin
            exp_qv = 1'b0;
         end
      end
      if (acc && exp_cnt != 16'hFFFF) exp_cnt++;
      @(posedge clk);
      #1;
      chk("q_valid", {31'd0, q_valid}, {31'd0, exp_qv});
      if (exp_qv) begin
         chk("q_data", {24'd0, Q}, {24'd0, exp_q});
         chk("q_sel", {30'd0, q_sel}, {30'd0, exp_qs});
      end
      chk("accept_cnt", {16'd0, accept_cnt}, {16'd0, exp_cnt});
   endtask

   task automatic edge3();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      exp_qv   = 1'b0;
      exp_q    = '0;
      exp_qs   = '0;
      exp_cnt  = '0;
      rst_n    = 1'b0;
      en       = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      sel      = '0;
      data     = '0;
      en3       = 1'b0;
      flush3    = 1'b0;
      in_valid3 = 1'b0;
      sel3      = '0;
      data3     = '0;

      // Reset state
      #3;
      chk("rst_q", {24'd0, Q}, 32'd0);
      chk("rst_q_valid", {31'd0, q_valid}, 32'd0);
      chk("rst_q_sel", {30'd0, q_sel}, 32'd0);
      chk("rst_sel_err", {31'd0, sel_err}, 32'd0);
      chk("rst_accept_cnt", {16'd0, accept_cnt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Streaming, channel 2 first
      data = 32'h4433_2211; sel = 2'd2; in_valid = 1'b1; en = 1'b1;
      step();
      step();
      sel = 2'd0; step();
      data = 32'hA5B6_C7D8; sel = 2'd3; step();
      sel = 2'd1; step();
      in_valid = 1'b0; step();
      step();

      // Stall with a beat on the output and one in stage 0
      data = 32'h0F1E_2D3C; sel = 2'd2; in_valid = 1'b1; step();
      sel = 2'd0; step();
      in_valid = 1'b0; en = 1'b0;
      step(); step(); step();
      en = 1'b1; step();
      step();

      // Flush with two valid beats in flight
      data = 32'h1122_3344; sel = 2'd1; in_valid = 1'b1; step();
      sel = 2'd3; step();
      flush = 1'b1; sel = 2'd2; step();
      flush = 1'b0; in_valid = 1'b0; step();
      step();

      // Asynchronous reset between edges
      data = 32'hDEAD_BEEF; sel = 2'd0; in_valid = 1'b1; step();
      step();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_q", {24'd0, Q}, 32'd0);
      chk("arst_q_valid", {31'd0, q_valid}, 32'd0);
      chk("arst_q_sel", {30'd0, q_sel}, 32'd0);
      chk("arst_accept_cnt", {16'd0, accept_cnt}, 32'd0);
      sb.delete();
      exp_qv  = 1'b0;
      exp_cnt = '0;
      #1 rst_n = 1'b1;
      step();
      sel = 2'd1; step();

      // Saturation of the accept counter
      en = 1'b0; in_valid = 1'b0;
      force dut.r_accept_cnt = 16'hFFFE;
      exp_cnt = 16'hFFFE;
      step();
      release dut.r_accept_cnt;
      en = 1'b1; in_valid = 1'b1; data = 32'h0102_0304; sel = 2'd3;
      step(); step(); step(); step();
      flush = 1'b1; step();
      flush = 1'b0; in_valid = 1'b0; step();
      chk("sel_err_never", {31'd0, sel_err}, 32'd0);
      en = 1'b0;

      // Out-of-range select on a three-channel instance
      en3 = 1'b1; in_valid3 = 1'b1; sel3 = 2'd1; data3 = 24'h33_2211;
      edge3();
      chk("bad_cnt_good", {16'd0, accept_cnt3}, 32'd1);
      chk("bad_err_clear", {31'd0, sel_err3}, 32'd0);
      sel3 = 2'd3;
      edge3();
      chk("bad_err_set", {31'd0, sel_err3}, 32'd1);
      chk("bad_cnt_hold", {16'd0, accept_cnt3}, 32'd1);
      chk("bad_prev_valid", {31'd0, q_valid3}, 32'd1);
      chk("bad_prev_q", {24'd0, Q3}, 32'h22);
      in_valid3 = 1'b0; sel3 = 2'd0;
      edge3();
      chk("bad_q_valid", {31'd0, q_valid3}, 32'd0);
      chk("bad_q_zero", {24'd0, Q3}, 32'd0);
      chk("bad_err_sticky", {31'd0, sel_err3}, 32'd1);
      in_valid3 = 1'b1; sel3 = 2'd2;
      edge3();
      chk("bad_cnt_resume", {16'd0, accept_cnt3}, 32'd2);
      in_valid3 = 1'b0;
      edge3();
      chk("bad_after_q", {24'd0, Q3}, 32'h33);
      chk("bad_after_valid", {31'd0, q_valid3}, 32'd1);
      chk("bad_err_still", {31'd0, sel_err3}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mux_dff_pipe.md
MUX_DFF_PIPE -- requirements
Module: mux_dff_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data width per channel (1..64).
REQ-002 Parameter CHANNELS, default 4, number of input channels (2..16).
REQ-003 Parameter DEPTH, default 2, number of register stages from mux to output (1..8).
REQ-004 Constant SEL_W = max(1, clog2(CHANNELS)), the select width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  pipeline advance; 0 = all stages hold.
REQ-008 flush  input  1  synchronous clear of all stage valids.
REQ-009 in_valid  input  1  current input beat is meaningful.
REQ-010 sel  input  SEL_W  channel select.
REQ-011 data  input  CHANNELS*WIDTH  flattened channel bus; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-012 Q  output  WIDTH  final-stage data.
REQ-013 q_valid  output  1  final-stage valid.
REQ-014 q_sel  output  SEL_W  channel tag carried with final-stage data.
REQ-015 sel_err  output  1  sticky flag for an out-of-range select.
REQ-016 accept_cnt  output  16  saturating count of accepted beats.

Function
REQ-017 Stage 0 SHALL capture data[sel], sel and (in_valid AND sel<CHANNELS) on a rising edge with en=1.
REQ-018 Stage i (i>=1) SHALL capture stage i-1 data, tag and valid on the same edge; Q, q_valid and q_sel SHALL be stage DEPTH-1.
REQ-019 Latency: a beat presented at edge n SHALL appear on Q at edge n+DEPTH-1, given en=1 on every intervening edge.
REQ-020 With en=0, every stage (data, tag, valid) SHALL hold its value.
REQ-021 flush=1 SHALL clear every stage valid on the edge, regardless of en; data and tag registers hold. The stage-0 capture in that cycle SHALL be discarded.
REQ-022 flush with en=1 and in_valid=1 SHALL NOT increment accept_cnt.
REQ-023 A select with sel>=CHANNELS (only possible when CHANNELS is not a power of 2) SHALL load zero data with valid=0, SHALL set sel_err when en=1 and in_valid=1, and SHALL NOT count as accepted.
REQ-024 sel_err SHALL remain 1 until reset.
REQ-025 accept_cnt SHALL increment by 1 on each edge with en=1, in_valid=1, flush=0 and sel<CHANNELS, and SHALL saturate at 16'hFFFF without wrapping.
REQ-026 Only valid bits gate downstream use; Q with q_valid=0 is don't-care for consumers but SHALL remain deterministic (held or reset value).

Reset
REQ-027 rst_n=0 SHALL immediately, with no clock required, clear all stage data to 0, tags to 0, valids to 0, sel_err to 0 and accept_cnt to 0.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight beats; there SHALL be no q_valid pulse on the first edge after release.
REQ-029 Reset release SHALL be treated as synchronised externally; the first capture occurs on the first rising edge with rst_n=1.

Structure
REQ-030 A shared package SHALL hold the SEL_W computation function and the accept-counter width constant (16).
REQ-031 One sub-module, mux_dff_stage (WIDTH+SEL_W+1-bit register with enable, flush-on-valid and async reset), SHALL be instantiated DEPTH times via generate.
REQ-032 The mux SHALL be purely combinational, in the top level, ahead of stage 0.

Verification
REQ-033 Reset then streaming: CHANNELS=4, DEPTH=2, data={8'h44,8'h33,8'h22,8'h11}, sel=2, in_valid=1, en=1 -> Q=8'h33, q_sel=2, q_valid=1 one edge after the first capture; accept_cnt counts 1, 2, ...
REQ-034 Stall: drop en for 3 cycles while a beat is in flight -> Q, q_valid and q_sel are unchanged over the 3 cycles, and the beat emerges after en returns with total en-high edges equal to DEPTH.
REQ-035 Flush: assert flush for 1 cycle with 2 valid beats in flight -> q_valid=0 for the next DEPTH edges with no new input; accept_cnt excludes the flush-cycle beat.
REQ-036 Bad select: CHANNELS=3, sel=3, in_valid=1 -> sel_err=1 sticky, and the beat later appears with q_valid=0 and Q=0; accept_cnt is unchanged.
REQ-037 Async reset mid-stream: pulse rst_n low between edges -> all outputs go to 0 immediately, with no stale q_valid after release.
REQ-038 Saturation: preload via a long run (or force) to 16'hFFFE, then 3 accepted beats -> accept_cnt=16'hFFFF and holds there.
